// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
// Wide adder sequencer: adds two 4*NIBBLES-bit operands by reusing one external
// 4-bit ripple-carry slice, one nibble per cycle, least significant nibble first.
// The carry between nibbles is held in a register so the slice can be shared.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; slice inputs parked at zero
// RUN   | one nibble per cycle through the slice, idx selects nibble
// DONE  | result valid, done pulses; a new start is accepted here
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [4*NIBBLES-1:0]   a_i,
    input  logic [4*NIBBLES-1:0]   b_i,
    input  logic                   cin_i,
    output logic [3:0]             slice_a_o,
    output logic [3:0]             slice_b_o,
    output logic                   slice_cin_o,
    input  logic [3:0]             slice_s_i,
    input  logic                   slice_c4_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [4*NIBBLES-1:0]   sum_o,
    output logic                   cout_o,
    output logic                   zero_o
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state_q;
    logic [IW-1:0]              idx_q;
    logic                       carry_q;
    logic [NIBBLES-1:0][3:0]    a_q;
    logic [NIBBLES-1:0][3:0]    b_q;
    logic [NIBBLES-1:0][3:0]    sum_q;
    logic [NIBBLES-1:0][3:0]    sum_d;
    logic                       done_q;
    logic                       cout_q;
    logic                       zero_q;

    // Sum as it will look after this cycle's nibble lands; also feeds the zero flag
    // so it reflects the final nibble written on the same edge.
    always_comb begin
        sum_d         = sum_q;
        sum_d[idx_q]  = slice_s_i;
    end

    // Slice inputs come straight from registers and are parked at zero outside RUN.
    always_comb begin
        slice_a_o   = 4'h0;
        slice_b_o   = 4'h0;
        slice_cin_o = 1'b0;
        if (state_q == RUN) begin
            slice_a_o   = a_q[idx_q];
            slice_b_o   = b_q[idx_q];
            slice_cin_o = carry_q;
        end
    end

    // Sequencer: operand capture, nibble stepping, carry chaining and result flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        carry_q <= cin_i;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= slice_c4_i;
                    if (idx_q == IW'(NIBBLES - 1)) begin
                        cout_q  <= slice_c4_i;
                        done_q  <= 1'b1;
                        zero_q  <= (sum_d == '0);
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state_q == RUN);
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign zero_o = zero_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl with NIBBLES=4 and a behavioural 4-bit slice.
module tb_nibble_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a, b;
    logic        cin;
    logic [3:0]  slice_a, slice_b, slice_s;
    logic        slice_cin, slice_c4;
    logic        busy, done, cout, zero;
    logic [15:0] sum;
    logic [4:0]  slice_tot;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // External 4-bit adder slice
    assign slice_tot = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0000, slice_cin};
    assign slice_s   = slice_tot[3:0];
    assign slice_c4  = slice_tot[4];

    nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .a_i         (a),
        .b_i         (b),
        .cin_i       (cin),
        .slice_a_o   (slice_a),
        .slice_b_o   (slice_b),
        .slice_cin_o (slice_cin),
        .slice_s_i   (slice_s),
        .slice_c4_i  (slice_c4),
        .busy_o      (busy),
        .done_o      (done),
        .sum_o       (sum),
        .cout_o      (cout),
        .zero_o      (zero)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        zero;
        int          cin_cnt;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // Issue one start, then follow the operation until done (bounded).
    task automatic run_op(input logic [15:0] a_v, input logic [15:0] b_v, input logic c_v,
                          output int lat, output int runs, output int cins);
        a = a_v; b = b_v; cin = c_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; runs = 0; cins = 0;
        while (!done && lat < 20) begin
            if (busy) begin
                runs++;
                cins += int'(slice_cin);
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    int          lat, runs, cins, dcnt, cnt;
    logic [15:0] held_sum;
    logic [16:0] model;
    logic [15:0] op_a [5];
    logic [15:0] op_b [5];
    logic        op_c [5];

    initial begin
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 3};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 4};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0};
        vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 3};
        vecs[6] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0, 1};

        op_a[0] = 16'h1234; op_b[0] = 16'h4321; op_c[0] = 1'b0;
        op_a[1] = 16'hFFFF; op_b[1] = 16'h0001; op_c[1] = 1'b0;
        op_a[2] = 16'h00FF; op_b[2] = 16'hFF01; op_c[2] = 1'b1;
        op_a[3] = 16'h7FFF; op_b[3] = 16'h8001; op_c[3] = 1'b0;
        op_a[4] = 16'h0000; op_b[4] = 16'h0000; op_c[4] = 1'b1;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_zero", zero, 0);
        chk("rst_slice_a", slice_a, 0);
        chk("rst_slice_cin", slice_cin, 0);

        // Table-driven single operations
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat, runs, cins);
            chk($sformatf("vec%0d_latency", i), lat, 4);
            chk($sformatf("vec%0d_busy_cycles", i), runs, 4);
            chk($sformatf("vec%0d_slice_cin_cycles", i), cins, vecs[i].cin_cnt);
            chk($sformatf("vec%0d_sum", i), sum, vecs[i].sum);
            chk($sformatf("vec%0d_cout", i), cout, vecs[i].cout);
            chk($sformatf("vec%0d_zero", i), zero, vecs[i].zero);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_drop", i), done, 0);
            chk($sformatf("vec%0d_idle_busy", i), busy, 0);
            chk($sformatf("vec%0d_sum_hold", i), sum, vecs[i].sum);
            chk($sformatf("vec%0d_idle_slice_b", i), slice_b, 0);
        end

        // start during RUN is ignored
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 16'h7777; b = 16'h7777; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dcnt = 0; held_sum = '0;
        for (int c = 0; c < 10; c++) begin
            if (done) begin
                dcnt++;
                held_sum = sum;
            end
            @(posedge clk); #1;
        end
        chk("ignore_done_count", dcnt, 1);
        chk("ignore_sum", held_sum, 16'h3333);
        chk("ignore_cout", cout, 0);
        chk("ignore_idle", busy, 0);

        // leave a non-zero sum and cout=1 behind before the reset test
        run_op(16'hF000, 16'h1234, 1'b0, lat, runs, cins);
        chk("pre_rst_sum", sum, 16'h0234);
        chk("pre_rst_cout", cout, 1);
        @(posedge clk); #1;

        // reset in the 3rd RUN cycle
        a = 16'h5555; b = 16'h5555; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_rst_busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_cout", cout, 0);
        chk("mid_rst_done", done, 0);
        dcnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) dcnt++;
            @(posedge clk); #1;
        end
        chk("mid_rst_no_done", dcnt, 0);
        run_op(16'h0001, 16'h0001, 1'b0, lat, runs, cins);
        chk("post_rst_latency", lat, 4);
        chk("post_rst_sum", sum, 16'h0002);
        chk("post_rst_cout", cout, 0);
        @(posedge clk); #1;

        // start held high: accepted at every DONE, one result per 5 cycles
        a = op_a[0]; b = op_b[0]; cin = op_c[0]; start = 1'b1;
        @(posedge clk); #1;
        a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cnt = 0;
            do begin
                @(posedge clk); #1;
                cnt++;
                if (cnt == 1) begin
                    a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
                end
            end while (!done && cnt < 20);
            model = {1'b0, op_a[i]} + {1'b0, op_b[i]} + {16'h0000, op_c[i]};
            chk($sformatf("stream%0d_interval", i), cnt, (i == 0) ? 4 : 5);
            chk($sformatf("stream%0d_sum", i), sum, model[15:0]);
            chk($sformatf("stream%0d_cout", i), cout, model[16]);
            chk($sformatf("stream%0d_zero", i), zero, (model[15:0] == 16'h0000));
            if (i < 4) begin
                a = op_a[i+1]; b = op_b[i+1]; cin = op_c[i+1];
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk); #1;
        chk("stream_done_drop", done, 0);
        chk("stream_end_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
